// File: rtl/seq_det_pkg.sv
// Shared types, reset defaults and the pattern-length clamp for the sequence detector.
package seq_det_pkg;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

    localparam logic [15:0] DEF_PAT_INIT = 16'b0111;
    localparam int          DEF_LEN_INIT = 4;

    // Lengths beyond the physical history depth collapse to the full depth.
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter with synchronous clear (clear beats increment).
module seq_det_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial pattern detector with overlap / non-overlap modes.
// Optional match counter is built only when SEQ_DET_COUNT_EN is defined.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int                   MAX_LEN  = 8,
    parameter int                   CNT_W    = 8,
    parameter logic [MAX_LEN-1:0]   PAT_INIT = MAX_LEN'(DEF_PAT_INIT),
    parameter int                   LEN_INIT = DEF_LEN_INIT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       x,
    input  logic                       en,
    input  logic                       cfg_load,
    input  logic [MAX_LEN-1:0]         cfg_pattern,
    input  logic [$clog2(MAX_LEN):0]   cfg_len,
    input  logic                       cfg_overlap,
    input  logic                       count_clr,
    output logic                       y,
    output logic [CNT_W-1:0]           match_count
);

    localparam int LW = $clog2(MAX_LEN) + 1;

    logic [MAX_LEN-1:0] r_hist;
    logic [MAX_LEN-1:0] r_pat;
    logic [LW-1:0]      r_fill;
    logic [LW-1:0]      r_len;
    mode_e              r_mode;
    logic               r_y;

    logic [MAX_LEN-1:0] w_mask;
    logic [MAX_LEN-1:0] w_hist_shift;
    logic [LW-1:0]      w_fill_inc;
    logic               w_match;

    // Only the low r_len bits of history take part in the comparison.
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
        assign w_mask[gi] = (LW'(gi) < r_len);
    end

    assign w_hist_shift = {r_hist[MAX_LEN-2:0], x};
    assign w_fill_inc   = (r_fill >= r_len) ? r_len : r_fill + LW'(1);
    assign w_match      = en && !cfg_load && (r_len != '0) && (w_fill_inc == r_len)
                          && (((w_hist_shift ^ r_pat) & w_mask) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= PAT_INIT;
            r_len  <= LW'(clamp_len(LEN_INIT, MAX_LEN));
            r_mode <= MODE_OVL;
            r_y    <= 1'b0;
        end else if (cfg_load) begin
            // New configuration restarts detection; x on this edge is dropped.
            r_pat  <= cfg_pattern;
            r_len  <= LW'(clamp_len(int'(cfg_len), MAX_LEN));
            r_mode <= mode_e'(cfg_overlap);
            r_fill <= '0;
            r_y    <= 1'b0;
        end else begin
            r_y <= w_match;
            if (en) begin
                r_hist <= w_hist_shift;
                r_fill <= (w_match && (r_mode == MODE_NONOVL)) ? '0 : w_fill_inc;
            end
        end
    end

    assign y = r_y;

`ifdef SEQ_DET_COUNT_EN
    seq_det_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (count_clr),
        .inc   (w_match),
        .count (match_count)
    );
`else
    logic w_unused_count_clr;
    assign w_unused_count_clr = count_clr;
    assign match_count        = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised + directed bench for seq_detect_param, checked against a queue-based model.
module tb_seq_detect_param;

    localparam int MAXL    = 8;
    localparam int CW      = 2;
    localparam int CNT_SAT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       x = 1'b0;
    logic       en = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = 8'h00;
    logic [3:0] cfg_len = 4'd0;
    logic       cfg_overlap = 1'b0;
    logic       count_clr = 1'b0;
    logic       y;
    logic [1:0] match_count;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] ylog = '0;

    seq_detect_param #(
        .MAX_LEN (MAXL),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .x           (x),
        .en          (en),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .count_clr   (count_clr),
        .y           (y),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the bits received since the last restart, newest at the back.
    bit         q[$];
    logic [7:0] m_pat = 8'h07;
    int         m_len = 4;
    bit         m_ovl = 1'b1;
    bit         m_match;
    logic       exp_y = 1'b0;
    int         exp_cnt = 0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_pat = 8'h07; m_len = 4; m_ovl = 1'b1;
            exp_y = 1'b0;  exp_cnt = 0;
        end else begin
            m_match = 1'b0;
            if (cfg_load) begin
                m_pat = cfg_pattern;
                m_len = (int'(cfg_len) > MAXL) ? MAXL : int'(cfg_len);
                m_ovl = cfg_overlap;
                q.delete();
            end else if (en) begin
                q.push_back(x);
                while (q.size() > m_len) void'(q.pop_front());
                if (m_len > 0 && q.size() == m_len) begin
                    m_match = 1'b1;
                    for (int i = 0; i < m_len; i++)
                        if (q[i] != m_pat[m_len-1-i]) m_match = 1'b0;
                end
                if (m_match && !m_ovl) q.delete();
            end
            exp_y = m_match;
            if (count_clr) exp_cnt = 0;
            else if (m_match && exp_cnt < CNT_SAT) exp_cnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        check("y", 32'(y), 32'(exp_y));
`ifdef SEQ_DET_COUNT_EN
        check("match_count", 32'(match_count), 32'(exp_cnt));
`else
        check("match_count", 32'(match_count), 32'd0);
`endif
    end

    task automatic step(input logic r, input logic xv, input logic ev, input logic ld, input logic clr);
        @(negedge clk);
        rst = r; x = xv; en = ev; cfg_load = ld; count_clr = clr;
        @(posedge clk);
        #1;
        ylog = {ylog[14:0], y};
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        ylog = '0;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
        cfg_pattern = p; cfg_len = l; cfg_overlap = o;
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        ylog = '0;
    endtask

    task automatic run_bits(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b0, bits[i], 1'b1, 1'b0, 1'b0);
    endtask

    task automatic check_cnt(input string name, input int exp_on);
`ifdef SEQ_DET_COUNT_EN
        check(name, 32'(match_count), 32'(exp_on));
`else
        check(name, 32'(match_count), 32'd0);
`endif
    endtask

    initial begin
        do_reset();
        check("reset_y", 32'(y), 32'd0);
        check_cnt("reset_cnt", 0);

        // Default pattern 0111, overlap mode.
        run_bits(16'b0111110111, 10);
        $display("default_ovl  y=%b", ylog[9:0]);
        check("default_ovl_y", 32'(ylog[9:0]), 32'b0001000001);
        check_cnt("default_ovl_cnt", 2);

        do_reset();
        load(8'b1010, 4'd4, 1'b1);
        run_bits(16'b101010, 6);
        $display("p1010_ovl    y=%b", ylog[5:0]);
        check("p1010_ovl_y", 32'(ylog[5:0]), 32'b000101);
        load(8'b1010, 4'd4, 1'b0);
        run_bits(16'b101010, 6);
        $display("p1010_nonovl y=%b", ylog[5:0]);
        check("p1010_nonovl_y", 32'(ylog[5:0]), 32'b000100);

        do_reset();
        load(8'b0111, 4'd4, 1'b0);
        run_bits(16'b011110111, 9);
        $display("p0111_nonovl y=%b", ylog[8:0]);
        check("p0111_nonovl_y", 32'(ylog[8:0]), 32'b000100001);

        // Qualifier toggling: only en=1 cycles contribute bits.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        $display("en_toggle    y=%b", ylog[7:0]);
        check("en_toggle_y", 32'(ylog[7:0]), 32'b00000010);
        check_cnt("en_toggle_cnt", 1);

        // Reconfigure mid-sequence: earlier bits must not complete the new pattern.
        do_reset();
        run_bits(16'b011, 3);
        load(8'b0110, 4'd4, 1'b1);
        run_bits(16'b0110, 4);
        $display("cfg_midseq   y=%b", ylog[3:0]);
        check("cfg_midseq_y", 32'(ylog[3:0]), 32'b0001);

        // Length clamp and disabled detection.
        load(8'b10110111, 4'd12, 1'b1);
        run_bits(16'b10110111, 8);
        $display("len_clamp    y=%b", ylog[7:0]);
        check("len_clamp_y", 32'(ylog[7:0]), 32'b00000001);
        load(8'h00, 4'd0, 1'b1);
        run_bits(16'b00000000, 8);
        $display("len_zero     y=%b", ylog[7:0]);
        check("len_zero_y", 32'(ylog[7:0]), 32'd0);

        // Counter saturation, clear priority, reset discarding history.
        do_reset();
        load(8'b1, 4'd1, 1'b1);
        run_bits(16'b11111, 5);
        $display("len1_sat     y=%b cnt=%0d", ylog[4:0], match_count);
        check("len1_y", 32'(ylog[4:0]), 32'b11111);
        check_cnt("sat_cnt", CNT_SAT);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("clr_match_y", 32'(y), 32'd1);
        check_cnt("clr_prio_cnt", 0);
        do_reset();
        run_bits(16'b01, 2);
        do_reset();
        run_bits(16'b11, 2);
        $display("rst_midseq   y=%b", ylog[1:0]);
        check("rst_midseq_y", 32'(ylog[1:0]), 32'b00);

        // Randomised traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic ld;
            ld = ($urandom_range(49) == 0);
            if (ld) begin
                cfg_pattern = 8'($urandom);
                cfg_len     = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(4, 1));
                cfg_overlap = 1'($urandom);
            end
            step(($urandom_range(199) == 0), 1'($urandom), ($urandom_range(3) != 0), ld,
                 ($urandom_range(29) == 0));
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
